// File: rtl/pipeline_controller_if.sv
// Datapath-facing control bundle of the pipeline controller.
// master: datapath/hazard side (drives InstrD, ALUFlagsE, FlushE); slave: controller.
interface pipeline_controller_if;
   logic [31:12] InstrD;
   logic [3:0]   ALUFlagsE;
   logic         FlushE;
   logic [1:0]   RegSrcD;
   logic [1:0]   ImmSrcD;
   logic         ALUSrcE;
   logic [3:0]   ALUControlE;
   logic         BranchTakenE;
   logic         MemtoRegE;
   logic         MemWriteM;
   logic         RegWriteM;
   logic         RegWriteW;
   logic         MemtoRegW;
   logic         PCSrcW;
   logic         PCWrPendingF;

   modport master (
      output InstrD, ALUFlagsE, FlushE,
      input  RegSrcD, ImmSrcD, ALUSrcE, ALUControlE,
      input  BranchTakenE, MemtoRegE, MemWriteM, RegWriteM,
      input  RegWriteW, MemtoRegW, PCSrcW, PCWrPendingF
   );

   modport slave (
      input  InstrD, ALUFlagsE, FlushE,
      output RegSrcD, ImmSrcD, ALUSrcE, ALUControlE,
      output BranchTakenE, MemtoRegE, MemWriteM, RegWriteM,
      output RegWriteW, MemtoRegW, PCSrcW, PCWrPendingF
   );
endinterface

// File: rtl/pipeline_controller.sv
// Control path of the 5-stage pipeline: decode, E/M/W control regs, NZCV flags.
// Ports: clk, reset (async active-low), bus (pipeline_controller_if.slave).
module pipeline_controller (
   input logic                 clk,
   input logic                 reset,
   pipeline_controller_if.slave bus
);

   typedef struct packed {
      logic       regw;
      logic       memw;
      logic       mtr;
      logic       br;
      logic       asrc;
      logic [3:0] alu;
      logic [1:0] flagw;
      logic       pcs;
      logic [3:0] cond;
   } de_t;

   typedef struct packed {
      logic regw;
      logic memw;
      logic mtr;
      logic pcs;
   } em_t;

   typedef struct packed {
      logic regw;
      logic mtr;
      logic pcs;
   } mw_t;

   de_t de_d, de_q;
   em_t em_d, em_q;
   mw_t mw_q;
   logic [3:0] flags_d, flags_q;

   logic [1:0] op;
   logic       imm, sbit;
   logic [3:0] cmd, rd;
   logic [1:0] regsrc, immsrc;
   logic       asrc, mtr, regw, memw, br, aluop;
   logic [3:0] aluctl;
   logic [1:0] flagw;
   logic       is_cmp, arith, known;
   logic       regw_d, pcs_d;
   logic       cond_ok;
   logic       unused_rn;

   assign op   = bus.InstrD[27:26];
   assign imm  = bus.InstrD[25];
   assign cmd  = bus.InstrD[24:21];
   assign sbit = bus.InstrD[20];
   assign rd   = bus.InstrD[15:12];
   assign unused_rn = ^bus.InstrD[19:16];

   always_comb begin
      regsrc = 2'b00;
      immsrc = 2'b00;
      asrc   = 1'b0;
      mtr    = 1'b0;
      regw   = 1'b0;
      memw   = 1'b0;
      br     = 1'b0;
      aluop  = 1'b0;
      unique case (1'b1)
         (op == 2'b00): begin
            asrc  = imm;
            regw  = 1'b1;
            aluop = 1'b1;
         end
         (op == 2'b01 && !sbit): begin
            regsrc = 2'b10;
            immsrc = 2'b01;
            asrc   = 1'b1;
            memw   = 1'b1;
         end
         (op == 2'b01 && sbit): begin
            immsrc = 2'b01;
            asrc   = 1'b1;
            mtr    = 1'b1;
            regw   = 1'b1;
         end
         (op == 2'b10): begin
            regsrc = 2'b01;
            immsrc = 2'b10;
            asrc   = 1'b1;
            br     = 1'b1;
         end
         default: ;
      endcase
   end

   always_comb begin
      aluctl = 4'b0000;
      is_cmp = 1'b0;
      arith  = 1'b0;
      known  = 1'b1;
      case (cmd)
         4'b0100: arith = 1'b1;
         4'b0010: begin aluctl = 4'b0001; arith = 1'b1; end
         4'b0000: aluctl = 4'b0010;
         4'b1100: aluctl = 4'b0011;
         4'b0001: aluctl = 4'b0100;
         4'b1101: aluctl = 4'b0101;
         4'b1010: begin
            aluctl = 4'b0001;
            arith  = 1'b1;
            is_cmp = 1'b1;
         end
         default: known = 1'b0;
      endcase
      if (!aluop) begin
         aluctl = 4'b0000;
         is_cmp = 1'b0;
         arith  = 1'b0;
         known  = 1'b1;
      end
   end

   // CMP and unknown DP commands never write the register file
   assign regw_d   = regw & known & ~is_cmp;
   assign flagw[1] = aluop & (sbit | is_cmp);
   assign flagw[0] = flagw[1] & arith;
   assign pcs_d    = regw_d & (rd == 4'hF);

   always_comb begin
      de_d       = '0;
      de_d.asrc  = asrc;
      de_d.alu   = aluctl;
      de_d.cond  = bus.InstrD[31:28];
      if (!bus.FlushE) begin
         de_d.regw  = regw_d;
         de_d.memw  = memw;
         de_d.mtr   = mtr;
         de_d.br    = br;
         de_d.flagw = flagw;
         de_d.pcs   = pcs_d;
      end
   end

   logic fn, fz, fc, fv;
   assign {fn, fz, fc, fv} = flags_q;

   always_comb begin
      case (de_q.cond)
         4'h0: cond_ok = fz;
         4'h1: cond_ok = ~fz;
         4'h2: cond_ok = fc;
         4'h3: cond_ok = ~fc;
         4'h4: cond_ok = fn;
         4'h5: cond_ok = ~fn;
         4'h6: cond_ok = fv;
         4'h7: cond_ok = ~fv;
         4'h8: cond_ok = fc & ~fz;
         4'h9: cond_ok = ~fc | fz;
         4'hA: cond_ok = (fn == fv);
         4'hB: cond_ok = (fn != fv);
         4'hC: cond_ok = ~fz & (fn == fv);
         4'hD: cond_ok = fz | (fn != fv);
         4'hE: cond_ok = 1'b1;
         default: cond_ok = 1'b0;
      endcase
   end

   always_comb begin
      em_d.regw = de_q.regw & cond_ok;
      em_d.memw = de_q.memw & cond_ok;
      em_d.mtr  = de_q.mtr;
      em_d.pcs  = de_q.pcs & cond_ok;
      flags_d   = flags_q;
      if (de_q.flagw[1] && cond_ok)
         flags_d[3:2] = bus.ALUFlagsE[3:2];
      if (de_q.flagw[0] && cond_ok)
         flags_d[1:0] = bus.ALUFlagsE[1:0];
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         de_q    <= '0;
         em_q    <= '0;
         mw_q    <= '0;
         flags_q <= '0;
      end else begin
         de_q    <= de_d;
         em_q    <= em_d;
         mw_q    <= '{regw: em_q.regw, mtr: em_q.mtr, pcs: em_q.pcs};
         flags_q <= flags_d;
      end
   end

   assign bus.RegSrcD      = regsrc;
   assign bus.ImmSrcD      = immsrc;
   assign bus.ALUSrcE      = de_q.asrc;
   assign bus.ALUControlE  = de_q.alu;
   assign bus.BranchTakenE = de_q.br & cond_ok;
   assign bus.MemtoRegE    = de_q.mtr;
   assign bus.MemWriteM    = em_q.memw;
   assign bus.RegWriteM    = em_q.regw;
   assign bus.RegWriteW    = mw_q.regw;
   assign bus.MemtoRegW    = mw_q.mtr;
   assign bus.PCSrcW       = mw_q.pcs;
   assign bus.PCWrPendingF = pcs_d | em_d.pcs | em_q.pcs;

endmodule
